// File: rtl/regfile_wb_arbiter_if.sv
// Register-file write-port bundle: pipeline writeback, MDU result
// handshake, the single write port and the MDU pending mask.
interface regfile_wb_arbiter_if;
  logic        wb_valid_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        wb_ready_o;
  logic        mdu_valid_i;
  logic [4:0]  mdu_addr_i;
  logic [31:0] mdu_data_i;
  logic        mdu_ready_o;
  logic        RegWrite_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;
  logic [31:0] pending_o;

  modport master (
    output wb_valid_i, wb_addr_i, wb_data_i,
    output mdu_valid_i, mdu_addr_i, mdu_data_i,
    input  wb_ready_o, mdu_ready_o,
    input  RegWrite_o, RDaddr_o, RDdata_o,
    input  pending_o
  );

  modport slave (
    input  wb_valid_i, wb_addr_i, wb_data_i,
    input  mdu_valid_i, mdu_addr_i, mdu_data_i,
    output wb_ready_o, mdu_ready_o,
    output RegWrite_o, RDaddr_o, RDdata_o,
    output pending_o
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter: pipeline first, MDU results via FIFO + starve guard.
// Ports: clk_i, rst_n_i, bus (slave). Option macro: WBARB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_WB,
    SEL_FIFO,
    SEL_MDU
  } sel_e;

  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             force_q, force_d;

  sel_e        sel;
  logic        empty, full, push, pop;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [31:0] pend;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  always_comb begin
    sel = SEL_NONE;
    if (force_q)
      sel = SEL_FIFO;
    else if (bus.wb_valid_i)
      sel = SEL_WB;
    else if (!empty)
      sel = SEL_FIFO;
`ifdef WBARB_BYPASS_EN
    else if (bus.mdu_valid_i)
      sel = SEL_MDU;
`else
    else
      sel = SEL_NONE;
`endif
  end

  always_comb begin
    w_addr = '0;
    w_data = '0;
    unique case (sel)
      SEL_WB: begin
        w_addr = bus.wb_addr_i;
        w_data = bus.wb_data_i;
      end
      SEL_FIFO: begin
        w_addr = addr_q[rd_ptr_q];
        w_data = data_q[rd_ptr_q];
      end
      SEL_MDU: begin
        w_addr = bus.mdu_addr_i;
        w_data = bus.mdu_data_i;
      end
      default: begin
        w_addr = '0;
        w_data = '0;
      end
    endcase
  end

  // $zero writes are still consumed, only the enable is dropped
  assign bus.RegWrite_o  = (sel != SEL_NONE) && (w_addr != '0);
  assign bus.RDaddr_o    = w_addr;
  assign bus.RDdata_o    = w_data;
  assign bus.wb_ready_o  = !force_q;
  assign bus.mdu_ready_o = !full;

  assign pop  = (sel == SEL_FIFO);
  assign push = bus.mdu_valid_i && !full &&
                (bus.mdu_addr_i != '0) && (sel != SEL_MDU);

  always_comb begin
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + AW'(1);
    end
    if (push) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // Head blocked this cycle: count toward a forced slot
  always_comb begin
    starve_d = '0;
    force_d  = 1'b0;
    if (!empty && !pop) begin
      if (32'(starve_q) + 32'd1 == 32'(STARVE_LIMIT))
        force_d = 1'b1;
      else
        starve_d = starve_q + SW'(1);
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i])
        pend[addr_q[i]] = 1'b1;
    pend[0] = 1'b0;
  end

  assign bus.pending_o = pend;

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.mdu_addr_i;
      data_q[wr_ptr_q] <= bus.mdu_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      force_q  <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      force_q  <= force_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table plus
// sequences for starvation, full FIFO and mid-drain reset.
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [31:0] ep;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic [4:0] wa,
                       input logic [31:0] wd, input logic mv,
                       input logic [4:0] ma, input logic [31:0] md);
    bus.wb_valid_i  = wv;
    bus.wb_addr_i   = wa;
    bus.wb_data_i   = wd;
    bus.mdu_valid_i = mv;
    bus.mdu_addr_i  = ma;
    bus.mdu_data_i  = md;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    tbl[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,
                1, 5, 32'hDEADBEEF, 0};
    tbl[1]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 0,
                0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 1, 0, 32'h1, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`ifdef WBARB_BYPASS_EN
    tbl[5]  = '{0, 0, 0, 1, 9, 32'h12345678,
                1, 9, 32'h12345678, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
    tbl[5]  = '{0, 0, 0, 1, 9, 32'h12345678,
                0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0,
                1, 9, 32'h12345678, 32'h200};
`endif
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 7, 32'hA5A5A5A5, 1, 12, 32'h0BADF00D,
                1, 7, 32'hA5A5A5A5, 0};
    tbl[9]  = '{1, 3, 32'hC0FFEE00, 0, 0, 0,
                1, 3, 32'hC0FFEE00, 32'h1000};
    tbl[10] = '{0, 0, 0, 0, 0, 0,
                1, 12, 32'h0BADF00D, 32'h1000};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    #12;
    chk("rst_we", 32'(bus.RegWrite_o), 0);
    chk("rst_addr", 32'(bus.RDaddr_o), 0);
    chk("rst_data", bus.RDdata_o, 0);
    chk("rst_wbrdy", 32'(bus.wb_ready_o), 1);
    chk("rst_mdurdy", 32'(bus.mdu_ready_o), 1);
    chk("rst_pend", bus.pending_o, 0);
    #5 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].wv, tbl[i].wa, tbl[i].wd,
            tbl[i].mv, tbl[i].ma, tbl[i].md);
      #3;
      chk($sformatf("v%0d_we", i), 32'(bus.RegWrite_o),
          32'(tbl[i].ewe));
      if (tbl[i].ewe) begin
        chk($sformatf("v%0d_addr", i), 32'(bus.RDaddr_o),
            32'(tbl[i].ea));
        chk($sformatf("v%0d_data", i), bus.RDdata_o, tbl[i].ed);
      end
      chk($sformatf("v%0d_pend", i), bus.pending_o, tbl[i].ep);
      chk($sformatf("v%0d_wbrdy", i), 32'(bus.wb_ready_o), 1);
      chk($sformatf("v%0d_mdurdy", i), 32'(bus.mdu_ready_o), 1);
      tick();
    end

    // starvation: head blocked 8 cycles, forced slot in cycle 9
    drive(1, 1, 32'h100, 1, 20, 32'h0000ABCD);
    #3 chk("st_c0_addr", 32'(bus.RDaddr_o), 1);
    tick();
    bus.mdu_valid_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      bus.wb_addr_i = 5'(k);
      bus.wb_data_i = 32'h100 + 32'(k);
      #3;
      chk($sformatf("st_c%0d_rdy", k), 32'(bus.wb_ready_o), 1);
      chk($sformatf("st_c%0d_addr", k), 32'(bus.RDaddr_o), k);
      chk($sformatf("st_c%0d_pend", k), bus.pending_o,
          32'h0010_0000);
      tick();
    end
    bus.wb_addr_i = 5'd9;
    #3;
    chk("st_c9_rdy", 32'(bus.wb_ready_o), 0);
    chk("st_c9_we", 32'(bus.RegWrite_o), 1);
    chk("st_c9_addr", 32'(bus.RDaddr_o), 20);
    chk("st_c9_data", bus.RDdata_o, 32'h0000ABCD);
    tick();
    #3;
    chk("st_c10_rdy", 32'(bus.wb_ready_o), 1);
    chk("st_c10_addr", 32'(bus.RDaddr_o), 9);
    chk("st_c10_pend", bus.pending_o, 0);
    tick();

    // full FIFO under continuous pipeline traffic
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'(k + 16), 32'h0, 1, 5'(k + 1), 32'h100 + 32'(k));
      #3 chk($sformatf("ff_p%0d_rdy", k), 32'(bus.mdu_ready_o), 1);
      tick();
    end
    drive(1, 16, 0, 1, 5, 32'h55);
    #3;
    chk("ff_c4_rdy", 32'(bus.mdu_ready_o), 0);
    chk("ff_c4_pend", bus.pending_o, 32'h1E);
    tick();
    #3 chk("ff_c5_rdy", 32'(bus.mdu_ready_o), 0);
    tick();
    bus.wb_valid_i = 1'b0;
    #3;
    chk("ff_c6_addr", 32'(bus.RDaddr_o), 1);
    chk("ff_c6_rdy", 32'(bus.mdu_ready_o), 0);
    tick();
    #3;
    chk("ff_c7_addr", 32'(bus.RDaddr_o), 2);
    chk("ff_c7_rdy", 32'(bus.mdu_ready_o), 1);
    tick();
    bus.mdu_valid_i = 1'b0;
    #3;
    chk("ff_c8_addr", 32'(bus.RDaddr_o), 3);
    chk("ff_c8_pend", bus.pending_o, 32'h38);
    tick();
    #3 chk("ff_c9_addr", 32'(bus.RDaddr_o), 4);
    tick();
    #3;
    chk("ff_c10_addr", 32'(bus.RDaddr_o), 5);
    chk("ff_c10_data", bus.RDdata_o, 32'h55);
    tick();
    #3;
    chk("ff_c11_we", 32'(bus.RegWrite_o), 0);
    chk("ff_c11_pend", bus.pending_o, 0);
    tick();

    // reset mid-drain with three entries queued
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 32'h1, 1, 5'(k + 6), 32'h200 + 32'(k));
      tick();
    end
    bus.mdu_valid_i = 1'b0;
    #3 chk("rs_pre_pend", bus.pending_o, 32'h1C0);
    bus.wb_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rs_pend", bus.pending_o, 0);
    chk("rs_we", 32'(bus.RegWrite_o), 0);
    chk("rs_mdurdy", 32'(bus.mdu_ready_o), 1);
    chk("rs_wbrdy", 32'(bus.wb_ready_o), 1);
    tick();
    #2 rst_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      #3;
      chk($sformatf("rs_post%0d_we", k), 32'(bus.RegWrite_o), 0);
      chk($sformatf("rs_post%0d_pend", k), bus.pending_o, 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
